// File: rtl/axi_isolate_pkg.sv
// Shared types and helpers for the AXI isolate/drain block.
// No logic; the state encoding is shared with the bench only through the top's behaviour.
package axi_isolate_pkg;

    typedef enum logic [2:0] {
        ST_NORMAL,
        ST_DRAIN,
        ST_ISOLATED,
        ST_TERM_W,
        ST_TERM_B,
        ST_TERM_R
    } isolate_state_e;

    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

    function automatic int unsigned cnt_width(input int unsigned max_outstanding);
        return $clog2(max_outstanding + 1);
    endfunction

endpackage

// File: rtl/axi_bus_intf.sv
// AXI4 bus bundle (subset of sideband fields) with Master/Slave views.
// Pure wiring, no latency, no flow control of its own.
interface AXI_BUS #(
    parameter int unsigned AXI_ADDR_WIDTH = 32,
    parameter int unsigned AXI_DATA_WIDTH = 64,
    parameter int unsigned AXI_ID_WIDTH   = 10,
    parameter int unsigned AXI_USER_WIDTH = 6
);
    localparam int unsigned STRB_WIDTH = AXI_DATA_WIDTH / 8;

    logic [AXI_ID_WIDTH-1:0]   aw_id;
    logic [AXI_ADDR_WIDTH-1:0] aw_addr;
    logic [7:0]                aw_len;
    logic [2:0]                aw_size;
    logic [1:0]                aw_burst;
    logic [2:0]                aw_prot;
    logic [AXI_USER_WIDTH-1:0] aw_user;
    logic                      aw_valid;
    logic                      aw_ready;

    logic [AXI_DATA_WIDTH-1:0] w_data;
    logic [STRB_WIDTH-1:0]     w_strb;
    logic                      w_last;
    logic [AXI_USER_WIDTH-1:0] w_user;
    logic                      w_valid;
    logic                      w_ready;

    logic [AXI_ID_WIDTH-1:0]   b_id;
    logic [1:0]                b_resp;
    logic [AXI_USER_WIDTH-1:0] b_user;
    logic                      b_valid;
    logic                      b_ready;

    logic [AXI_ID_WIDTH-1:0]   ar_id;
    logic [AXI_ADDR_WIDTH-1:0] ar_addr;
    logic [7:0]                ar_len;
    logic [2:0]                ar_size;
    logic [1:0]                ar_burst;
    logic [2:0]                ar_prot;
    logic [AXI_USER_WIDTH-1:0] ar_user;
    logic                      ar_valid;
    logic                      ar_ready;

    logic [AXI_ID_WIDTH-1:0]   r_id;
    logic [AXI_DATA_WIDTH-1:0] r_data;
    logic [1:0]                r_resp;
    logic                      r_last;
    logic [AXI_USER_WIDTH-1:0] r_user;
    logic                      r_valid;
    logic                      r_ready;

    modport Master (
        output aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_prot, aw_user, aw_valid,
        input  aw_ready,
        output w_data, w_strb, w_last, w_user, w_valid,
        input  w_ready,
        input  b_id, b_resp, b_user, b_valid,
        output b_ready,
        output ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_prot, ar_user, ar_valid,
        input  ar_ready,
        input  r_id, r_data, r_resp, r_last, r_user, r_valid,
        output r_ready
    );

    modport Slave (
        input  aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_prot, aw_user, aw_valid,
        output aw_ready,
        input  w_data, w_strb, w_last, w_user, w_valid,
        output w_ready,
        output b_id, b_resp, b_user, b_valid,
        input  b_ready,
        input  ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_prot, ar_user, ar_valid,
        output ar_ready,
        output r_id, r_data, r_resp, r_last, r_user, r_valid,
        input  r_ready
    );

endinterface

// File: rtl/axi_isolate_cnt.sv
// Outstanding-transaction up/down counter with at-max and zero flags.
// Flags are combinational from the register; simultaneous inc/dec holds the value.
module axi_isolate_cnt
    import axi_isolate_pkg::*;
#(
    parameter int unsigned MAX = 8,
    parameter int unsigned W   = cnt_width(MAX)
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_inc,
    input  logic i_dec,
    output logic o_at_max,
    output logic o_is_zero
);
    logic [W-1:0] r_cnt;

    // A W burst may legally finish before its AW; the transient underflow nets out when the AW lands.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else if (i_inc && !i_dec) begin
            r_cnt <= r_cnt + 1'b1;
        end else if (i_dec && !i_inc) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_at_max  = (r_cnt == W'(MAX));
    assign o_is_zero = (r_cnt == '0);

endmodule

// File: rtl/axi_isolate_drain.sv
// AXI4 isolator: gates new AW/AR on isolate_i, drains in-flight bursts, then reports isolated.
// Zero added latency in NORMAL; isolated_o rises one cycle after drain; stalls by holding ready low.
module axi_isolate_drain
    import axi_isolate_pkg::*;
#(
    parameter int unsigned AXI_ADDR_WIDTH  = 32,
    parameter int unsigned AXI_DATA_WIDTH  = 64,
    parameter int unsigned AXI_USER_WIDTH  = 6,
    parameter int unsigned AXI_ID_WIDTH    = 10,
    parameter int unsigned MAX_OUTSTANDING = 8,
    parameter int unsigned TERMINATE       = 0
) (
    input  logic   clk_i,
    input  logic   rst_i,
    input  logic   isolate_i,
    output logic   isolated_o,
    output logic   busy_o,
    AXI_BUS.Slave  axi_slave,
    AXI_BUS.Master axi_master
);
    isolate_state_e          r_state;
    logic                    r_isolated, r_aw_hold, r_ar_hold;
    logic [AXI_ID_WIDTH-1:0] r_id;
    logic [7:0]              r_len, r_beat;

    logic w_wr_max, w_wr_zero, w_rd_max, w_rd_zero, w_w_max, w_w_zero;
    logic w_pass, w_aw_allow, w_ar_allow, w_term_aw, w_term_ar, w_term_b, w_term_r;
    logic w_aw_hs, w_ar_hs, w_b_hs, w_r_last_hs, w_w_last_hs;

    assign w_pass     = (r_state == ST_NORMAL) || (r_state == ST_DRAIN);
    // A request already shown downstream must stay valid until accepted, whatever the state.
    assign w_aw_allow = r_aw_hold || ((r_state == ST_NORMAL) && !w_wr_max && !w_w_max);
    assign w_ar_allow = r_ar_hold || ((r_state == ST_NORMAL) && !w_rd_max);
    assign w_term_aw  = (TERMINATE != 0) && (r_state == ST_ISOLATED) && isolate_i && axi_slave.aw_valid;
    assign w_term_ar  = (TERMINATE != 0) && (r_state == ST_ISOLATED) && isolate_i
                        && !axi_slave.aw_valid && axi_slave.ar_valid;
    assign w_term_b   = (r_state == ST_TERM_B);
    assign w_term_r   = (r_state == ST_TERM_R);

    assign axi_master.aw_id    = axi_slave.aw_id;
    assign axi_master.aw_addr  = AXI_ADDR_WIDTH'(axi_slave.aw_addr);
    assign axi_master.aw_len   = axi_slave.aw_len;
    assign axi_master.aw_size  = axi_slave.aw_size;
    assign axi_master.aw_burst = axi_slave.aw_burst;
    assign axi_master.aw_prot  = axi_slave.aw_prot;
    assign axi_master.aw_user  = axi_slave.aw_user;
    assign axi_master.aw_valid = axi_slave.aw_valid && w_aw_allow;
    assign axi_slave.aw_ready  = (w_aw_allow && axi_master.aw_ready) || w_term_aw;

    assign axi_master.w_data   = axi_slave.w_data;
    assign axi_master.w_strb   = axi_slave.w_strb;
    assign axi_master.w_last   = axi_slave.w_last;
    assign axi_master.w_user   = axi_slave.w_user;
    assign axi_master.w_valid  = axi_slave.w_valid && w_pass;
    assign axi_slave.w_ready   = (w_pass && axi_master.w_ready) || (r_state == ST_TERM_W);

    assign axi_slave.b_id      = w_term_b ? r_id : axi_master.b_id;
    assign axi_slave.b_resp    = w_term_b ? AXI_RESP_DECERR : axi_master.b_resp;
    assign axi_slave.b_user    = w_term_b ? {AXI_USER_WIDTH{1'b0}} : axi_master.b_user;
    assign axi_slave.b_valid   = w_term_b || (w_pass && axi_master.b_valid);
    assign axi_master.b_ready  = w_pass && axi_slave.b_ready;

    assign axi_master.ar_id    = axi_slave.ar_id;
    assign axi_master.ar_addr  = AXI_ADDR_WIDTH'(axi_slave.ar_addr);
    assign axi_master.ar_len   = axi_slave.ar_len;
    assign axi_master.ar_size  = axi_slave.ar_size;
    assign axi_master.ar_burst = axi_slave.ar_burst;
    assign axi_master.ar_prot  = axi_slave.ar_prot;
    assign axi_master.ar_user  = axi_slave.ar_user;
    assign axi_master.ar_valid = axi_slave.ar_valid && w_ar_allow;
    assign axi_slave.ar_ready  = (w_ar_allow && axi_master.ar_ready) || w_term_ar;

    assign axi_slave.r_id      = w_term_r ? r_id : axi_master.r_id;
    assign axi_slave.r_data    = w_term_r ? {AXI_DATA_WIDTH{1'b0}} : axi_master.r_data;
    assign axi_slave.r_resp    = w_term_r ? AXI_RESP_DECERR : axi_master.r_resp;
    assign axi_slave.r_last    = w_term_r ? (r_beat == r_len) : axi_master.r_last;
    assign axi_slave.r_user    = w_term_r ? {AXI_USER_WIDTH{1'b0}} : axi_master.r_user;
    assign axi_slave.r_valid   = w_term_r || (w_pass && axi_master.r_valid);
    assign axi_master.r_ready  = w_pass && axi_slave.r_ready;

    assign w_aw_hs     = axi_master.aw_valid && axi_master.aw_ready;
    assign w_ar_hs     = axi_master.ar_valid && axi_master.ar_ready;
    assign w_b_hs      = axi_master.b_valid && axi_master.b_ready;
    assign w_r_last_hs = axi_master.r_valid && axi_master.r_ready && axi_master.r_last;
    assign w_w_last_hs = axi_master.w_valid && axi_master.w_ready && axi_master.w_last;

    axi_isolate_cnt #(.MAX(MAX_OUTSTANDING)) u_wr_cnt (
        .i_clk(clk_i), .i_rst(rst_i), .i_inc(w_aw_hs), .i_dec(w_b_hs),
        .o_at_max(w_wr_max), .o_is_zero(w_wr_zero)
    );
    axi_isolate_cnt #(.MAX(MAX_OUTSTANDING)) u_rd_cnt (
        .i_clk(clk_i), .i_rst(rst_i), .i_inc(w_ar_hs), .i_dec(w_r_last_hs),
        .o_at_max(w_rd_max), .o_is_zero(w_rd_zero)
    );
    axi_isolate_cnt #(.MAX(MAX_OUTSTANDING)) u_w_cnt (
        .i_clk(clk_i), .i_rst(rst_i), .i_inc(w_aw_hs), .i_dec(w_w_last_hs),
        .o_at_max(w_w_max), .o_is_zero(w_w_zero)
    );

    assign busy_o     = !(w_wr_zero && w_rd_zero && w_w_zero);
    assign isolated_o = r_isolated;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_aw_hold <= 1'b0;
            r_ar_hold <= 1'b0;
        end else begin
            r_aw_hold <= axi_master.aw_valid && !axi_master.aw_ready;
            r_ar_hold <= axi_master.ar_valid && !axi_master.ar_ready;
        end
    end

    // isolated_o stays high through local termination; it only drops on the way back to NORMAL.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state    <= ST_NORMAL;
            r_isolated <= 1'b0;
            r_id       <= '0;
            r_len      <= '0;
            r_beat     <= '0;
        end else begin
            case (r_state)
                ST_NORMAL: begin
                    if (isolate_i) r_state <= ST_DRAIN;
                end
                ST_DRAIN: begin
                    if (!isolate_i) begin
                        r_state <= ST_NORMAL;
                    end else if (!busy_o && !r_aw_hold && !r_ar_hold) begin
                        r_state    <= ST_ISOLATED;
                        r_isolated <= 1'b1;
                    end
                end
                ST_ISOLATED: begin
                    if (!isolate_i) begin
                        r_state    <= ST_NORMAL;
                        r_isolated <= 1'b0;
                    end else if (w_term_aw) begin
                        r_id    <= axi_slave.aw_id;
                        r_state <= ST_TERM_W;
                    end else if (w_term_ar) begin
                        r_id    <= axi_slave.ar_id;
                        r_len   <= axi_slave.ar_len;
                        r_beat  <= '0;
                        r_state <= ST_TERM_R;
                    end
                end
                ST_TERM_W: begin
                    if (axi_slave.w_valid && axi_slave.w_last) r_state <= ST_TERM_B;
                end
                ST_TERM_B: begin
                    if (axi_slave.b_ready) r_state <= ST_ISOLATED;
                end
                ST_TERM_R: begin
                    if (axi_slave.r_ready) begin
                        if (r_beat == r_len) r_state <= ST_ISOLATED;
                        else                 r_beat  <= r_beat + 8'd1;
                    end
                end
                default: r_state <= ST_NORMAL;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_isolate_drain.sv
// Bench: two isolators (default stall mode, and MAX_OUTSTANDING=2 with local DECERR termination).
// Inputs are driven on the falling edge and outputs sampled 1 ns later.
module tb_axi_isolate_drain;
    logic clk = 1'b0;
    logic rst, iso0, iso1;
    logic isolated0, busy0, isolated1, busy1;
    int   n_chk = 0;
    int   n_fail = 0;
    logic [63:0] exp_q[$];

    always #5 clk = ~clk;

    AXI_BUS s0 ();
    AXI_BUS m0 ();
    AXI_BUS s1 ();
    AXI_BUS m1 ();

    axi_isolate_drain u0 (
        .clk_i(clk), .rst_i(rst), .isolate_i(iso0), .isolated_o(isolated0), .busy_o(busy0),
        .axi_slave(s0), .axi_master(m0)
    );
    axi_isolate_drain #(.MAX_OUTSTANDING(2), .TERMINATE(1)) u1 (
        .clk_i(clk), .rst_i(rst), .isolate_i(iso1), .isolated_o(isolated1), .busy_o(busy1),
        .axi_slave(s1), .axi_master(m1)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic sb_pop(input string tag, input logic [63:0] obs);
        if (exp_q.size() == 0) chk({tag, "_unexpected"}, 64'(1), 0);
        else                   chk(tag, obs, exp_q.pop_front());
    endtask

    task automatic init_bus();
        s0.aw_id = '0; s0.aw_addr = '0; s0.aw_len = '0; s0.aw_size = 3'd3; s0.aw_burst = 2'b01;
        s0.aw_prot = '0; s0.aw_user = '0; s0.aw_valid = 0;
        s0.w_data = '0; s0.w_strb = '1; s0.w_last = 0; s0.w_user = '0; s0.w_valid = 0; s0.b_ready = 0;
        s0.ar_id = '0; s0.ar_addr = '0; s0.ar_len = '0; s0.ar_size = 3'd3; s0.ar_burst = 2'b01;
        s0.ar_prot = '0; s0.ar_user = '0; s0.ar_valid = 0; s0.r_ready = 0;
        s1.aw_id = '0; s1.aw_addr = '0; s1.aw_len = '0; s1.aw_size = 3'd3; s1.aw_burst = 2'b01;
        s1.aw_prot = '0; s1.aw_user = '0; s1.aw_valid = 0;
        s1.w_data = '0; s1.w_strb = '1; s1.w_last = 0; s1.w_user = '0; s1.w_valid = 0; s1.b_ready = 0;
        s1.ar_id = '0; s1.ar_addr = '0; s1.ar_len = '0; s1.ar_size = 3'd3; s1.ar_burst = 2'b01;
        s1.ar_prot = '0; s1.ar_user = '0; s1.ar_valid = 0; s1.r_ready = 0;
        m0.aw_ready = 0; m0.w_ready = 0; m0.b_id = '0; m0.b_resp = '0; m0.b_user = '0; m0.b_valid = 0;
        m0.ar_ready = 0; m0.r_id = '0; m0.r_data = 64'hDEAD_BEEF; m0.r_resp = '0; m0.r_last = 0;
        m0.r_user = '0; m0.r_valid = 0;
        m1.aw_ready = 0; m1.w_ready = 0; m1.b_id = '0; m1.b_resp = '0; m1.b_user = '0; m1.b_valid = 0;
        m1.ar_ready = 0; m1.r_id = '0; m1.r_data = 64'hDEAD_BEEF; m1.r_resp = '0; m1.r_last = 0;
        m1.r_user = '0; m1.r_valid = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int leak;
        int early;
        int waited;
        rst = 1'b1; iso0 = 1'b0; iso1 = 1'b0;
        init_bus();

        // reset state
        repeat (3) @(negedge clk);
        #1;
        chk("rst_isolated0", 64'(isolated0), 0);
        chk("rst_busy0", 64'(busy0), 0);
        chk("rst_isolated1", 64'(isolated1), 0);
        chk("rst_busy1", 64'(busy1), 0);
        chk("rst_m0_aw_valid", 64'(m0.aw_valid), 0);

        // idle isolate: request at cycle 10, isolated at cycle 12
        @(negedge clk); rst = 1'b0;
        repeat (10) @(negedge clk);
        iso0 = 1'b1; #1;
        chk("t1_c10_isolated", 64'(isolated0), 0);
        @(negedge clk); s0.aw_valid = 1; s0.ar_valid = 1; m0.aw_ready = 1; m0.ar_ready = 1; #1;
        chk("t1_c11_isolated", 64'(isolated0), 0);
        chk("t1_c11_aw_gated", 64'(m0.aw_valid), 0);
        chk("t1_c11_ar_gated", 64'(m0.ar_valid), 0);
        @(negedge clk); #1;
        chk("t1_c12_isolated", 64'(isolated0), 1);
        chk("t1_c12_aw_gated", 64'(m0.aw_valid), 0);
        chk("t1_c12_ar_gated", 64'(m0.ar_valid), 0);
        chk("t1_c12_aw_ready", 64'(s0.aw_ready), 0);
        chk("t1_c12_ar_ready", 64'(s0.ar_ready), 0);
        @(negedge clk); s0.aw_valid = 0; s0.ar_valid = 0; m0.aw_ready = 0; m0.ar_ready = 0; iso0 = 0; #1;
        chk("t1_c13_isolated", 64'(isolated0), 1);
        @(negedge clk); #1;
        chk("t1_c14_released", 64'(isolated0), 0);

        // four AR len=3, isolate, 16 read beats drain
        m0.ar_ready = 1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            s0.ar_valid = 1; s0.ar_id = 10'(k + 1); s0.ar_len = 8'd3; #1;
            chk("t2_ar_pass", 64'(m0.ar_valid), 1);
            for (int b = 0; b < 4; b++) exp_q.push_back(64'({10'(k + 1), (b == 3)}));
        end
        @(negedge clk); s0.ar_valid = 0; iso0 = 1;
        @(negedge clk); s0.ar_valid = 1; s0.ar_id = 10'h3FF; s0.r_ready = 1;
        leak = 0; early = 0;
        for (int b = 0; b < 16; b++) begin
            @(negedge clk);
            m0.r_valid = 1; m0.r_id = 10'(b / 4 + 1); m0.r_last = (b % 4 == 3); #1;
            if (m0.ar_valid) leak++;
            if (isolated0) early++;
            if (s0.r_valid && s0.r_ready) sb_pop("t2_r_beat", 64'({s0.r_id, s0.r_last}));
        end
        @(negedge clk); m0.r_valid = 0; m0.r_last = 0; #1;
        if (m0.ar_valid) leak++;
        chk("t2_not_yet_isolated", 64'(isolated0), 0);
        chk("t2_busy_cleared", 64'(busy0), 0);
        @(negedge clk); #1;
        chk("t2_isolated", 64'(isolated0), 1);
        chk("t2_no_ar_leak", 64'(leak), 0);
        chk("t2_no_early_iso", 64'(early), 0);
        chk("t2_sb_empty", 64'(exp_q.size()), 0);
        @(negedge clk); s0.ar_valid = 0; s0.r_ready = 0; m0.ar_ready = 0; iso0 = 0;

        // MAX_OUTSTANDING=2: third AW blocked until first B
        @(negedge clk); m1.aw_ready = 1; m1.w_ready = 1; s1.b_ready = 1;
        s1.aw_valid = 1; s1.aw_id = 10'd1; #1;
        chk("t3_aw1_ready", 64'(s1.aw_ready), 1);
        @(negedge clk); s1.aw_id = 10'd2; #1;
        chk("t3_aw2_ready", 64'(s1.aw_ready), 1);
        @(negedge clk); s1.aw_id = 10'd3; #1;
        chk("t3_aw3_blocked", 64'(s1.aw_ready), 0);
        chk("t3_aw3_gated", 64'(m1.aw_valid), 0);
        @(negedge clk); s1.w_valid = 1; s1.w_last = 1; #1;
        chk("t3_w_ready", 64'(s1.w_ready), 1);
        @(negedge clk); #1;
        chk("t3_aw3_still_blocked", 64'(s1.aw_ready), 0);
        @(negedge clk); s1.w_valid = 0; m1.b_valid = 1; m1.b_id = 10'd1; #1;
        chk("t3_b1", 64'({s1.b_valid, s1.b_id}), 64'({1'b1, 10'd1}));
        chk("t3_aw3_blocked_b", 64'(s1.aw_ready), 0);
        @(negedge clk); m1.b_valid = 0; #1;
        chk("t3_aw3_accepted", 64'(s1.aw_ready), 1);
        @(negedge clk); s1.aw_valid = 0; m1.b_valid = 1; m1.b_id = 10'd2;
        @(negedge clk); m1.b_id = 10'd3; s1.w_valid = 1;
        @(negedge clk); m1.b_valid = 0; s1.w_valid = 0; s1.w_last = 0; #1;
        chk("t3_idle", 64'(busy1), 0);

        // AW stalled 5 cycles downstream, isolate rises mid-stall
        @(negedge clk); m0.aw_ready = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            s0.aw_valid = 1; s0.aw_id = 10'd7;
            if (i == 1) iso0 = 1;
            #1;
            chk("t4_aw_held", 64'(m0.aw_valid), 1);
        end
        @(negedge clk); m0.aw_ready = 1; #1;
        chk("t4_aw_hs", 64'({m0.aw_valid, s0.aw_ready}), 64'(2'b11));
        @(negedge clk); s0.aw_valid = 0; m0.aw_ready = 0; s0.w_valid = 1; s0.w_last = 1; m0.w_ready = 1; #1;
        chk("t4_busy", 64'(busy0), 1);
        chk("t4_w_pass", 64'(m0.w_valid), 1);
        @(negedge clk); s0.w_valid = 0; m0.b_valid = 1; m0.b_id = 10'd7; s0.b_ready = 1; #1;
        chk("t4_b_pass", 64'({s0.b_valid, s0.b_id}), 64'({1'b1, 10'd7}));
        chk("t4_not_isolated", 64'(isolated0), 0);
        @(negedge clk); m0.b_valid = 0; #1;
        chk("t4_drained", 64'({busy0, isolated0}), 0);
        @(negedge clk); #1;
        chk("t4_isolated", 64'(isolated0), 1);
        @(negedge clk); iso0 = 0; s0.w_last = 0; s0.b_ready = 0; m0.w_ready = 0;

        // local DECERR termination
        iso1 = 1; waited = 0;
        @(negedge clk); #1;
        while (!isolated1 && waited < 10) begin @(negedge clk); #1; waited++; end
        chk("t5_isolated", 64'(isolated1), 1);
        @(negedge clk); s1.ar_valid = 1; s1.ar_id = 10'h2A; s1.ar_len = 8'd2; s1.r_ready = 0; #1;
        chk("t5_ar_accept", 64'(s1.ar_ready), 1);
        chk("t5_ar_gated", 64'(m1.ar_valid), 0);
        for (int b = 0; b < 3; b++) exp_q.push_back(64'({10'h2A, 2'b11, (b == 2)}));
        for (int i = 0; i < 12; i++) begin
            @(negedge clk); s1.ar_valid = 0; s1.r_ready = (i % 2 == 1); #1;
            if (s1.r_valid && s1.r_ready) begin
                sb_pop("t5_r_beat", 64'({s1.r_id, s1.r_resp, s1.r_last}));
                chk("t5_r_data", s1.r_data, 0);
            end
        end
        chk("t5_r_all_seen", 64'(exp_q.size()), 0);
        @(negedge clk); s1.r_ready = 0; s1.aw_valid = 1; s1.aw_id = 10'h15; #1;
        chk("t5_aw_accept", 64'(s1.aw_ready), 1);
        chk("t5_aw_gated", 64'(m1.aw_valid), 0);
        exp_q.push_back(64'({10'h15, 2'b11}));
        @(negedge clk); s1.aw_valid = 0; s1.w_valid = 1; s1.w_last = 1; #1;
        chk("t5_w_accept", 64'({s1.w_ready, m1.w_valid}), 64'(2'b10));
        for (int i = 0; i < 6; i++) begin
            @(negedge clk); s1.w_valid = 0; s1.b_ready = 1; #1;
            if (s1.b_valid && s1.b_ready) sb_pop("t5_b", 64'({s1.b_id, s1.b_resp}));
        end
        chk("t5_b_all_seen", 64'(exp_q.size()), 0);
        chk("t5_still_isolated", 64'(isolated1), 1);
        @(negedge clk); iso1 = 0; s1.b_ready = 0;
        @(negedge clk); #1;
        chk("t5_released", 64'(isolated1), 0);

        // reset while draining three writes
        m0.aw_ready = 1;
        for (int k = 0; k < 3; k++) begin @(negedge clk); s0.aw_valid = 1; s0.aw_id = 10'(k); end
        @(negedge clk); s0.aw_valid = 0; m0.aw_ready = 0; iso0 = 1;
        @(negedge clk); #1;
        chk("t6_busy_drain", 64'(busy0), 1);
        @(negedge clk); #1;
        chk("t6_not_isolated", 64'(isolated0), 0);
        @(negedge clk); rst = 1;
        @(negedge clk); rst = 0; s0.aw_valid = 1; #1;
        chk("t6_busy_reset", 64'(busy0), 0);
        chk("t6_iso_reset", 64'(isolated0), 0);
        chk("t6_normal_pass", 64'(m0.aw_valid), 1);
        @(negedge clk); s0.aw_valid = 0; iso0 = 0;
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/axi_isolate_drain.md
Name: axi_isolate_drain

Overview:
- Single-clock AXI4 isolation unit between an upstream AXI_BUS master and a downstream slave, for power-domain or clock-domain shutdown.
- Generalises a plain combinational isolate: tracks outstanding transactions and enforces a parametrised outstanding limit.
- On isolation request it drains in-flight bursts before declaring the port isolated, without ever violating the AXI valid/ready rules.
- Optionally terminates new requests locally with DECERR while isolated.

Parameters:
- AXI_ADDR_WIDTH, 32, address width
- AXI_DATA_WIDTH, 64, data width
- AXI_USER_WIDTH, 6, user width
- AXI_ID_WIDTH, 10, ID width
- MAX_OUTSTANDING, 8, maximum outstanding writes and, separately, maximum outstanding reads; must be ≥1
- TERMINATE, 0, 0 = stall new requests while isolated; 1 = answer them locally with DECERR

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset; synchronous and active-high (decided)
- isolate_i  in  1  isolation request, level
- isolated_o  out  1  high when drained and isolated
- busy_o  out  1  high when any counter is nonzero
- axi_slave  AXI_BUS.Slave  intf  upstream port
- axi_master  AXI_BUS.Master  intf  downstream port

Behaviour:
- Payload fields pass straight through combinationally; only valid/ready are gated.
- Counters, each $clog2(MAX_OUTSTANDING+1) bits:
  - wr_cnt: +1 on downstream AW handshake, −1 on B handshake.
  - rd_cnt: +1 on AR handshake, −1 on R handshake with r_last.
  - w_cnt: +1 on AW handshake, −1 on W handshake with w_last.
  - Increment and decrement in the same cycle leave the counter unchanged.
  - Counters never wrap: a new request is blocked when the counter equals MAX_OUTSTANDING.
- Valid stability:
  - aw_hold_q is set when axi_master.aw_valid=1 and aw_ready=0; it clears on the handshake.
  - ar_hold_q behaves the same for AR.
  - While a hold flag is set, that channel passes through regardless of state or limit.
- FSM states: NORMAL, DRAIN, ISOLATED, TERM_W, TERM_B, TERM_R.
  - NORMAL: AW/AR pass when the limit allows; W/R/B always pass. isolate_i=1 → DRAIN.
  - DRAIN: new AW/AR are gated (hold flags excepted); W, R and B pass.
    - All counters 0 and no hold flag → ISOLATED.
    - isolate_i=0 → NORMAL; this takes priority over the ISOLATED transition.
  - ISOLATED: isolated_o=1. Downstream aw/ar/w valid = 0; upstream r/b valid = 0.
    - isolate_i=0 → NORMAL next cycle; isolated_o drops in that same transition.
    - TERMINATE=0: upstream aw/ar/w ready = 0.
    - TERMINATE=1: AW takes priority over AR. Accept AW (aw_ready=1 for one cycle), latch id → TERM_W. Otherwise accept AR, latch id and len → TERM_R.
  - TERM_W: w_ready=1, consume beats until w_last → TERM_B.
  - TERM_B: b_valid=1, b_resp=2'b11, latched b_id → ISOLATED on b_ready.
  - TERM_R: drive len+1 beats with r_resp=2'b11, r_data=0, latched r_id, r_last on the final beat. The beat counter advances only on r_ready → ISOLATED after the last beat.
    - A len=0 request produces one beat with r_last=1.
  - isolate_i deassertion during TERM_* is honoured only after returning to ISOLATED; the local response always completes.
- Reset (rst_i=1 at the clock edge):
  - State → NORMAL; all counters, hold flags and latches → 0.
  - isolated_o=0, busy_o=0; all locally driven valids 0.
  - Reset mid-burst discards the tracking state; the downstream side must be reset alongside.
- Latency: zero added cycles on every channel in NORMAL. The ISOLATED transition takes 1 cycle after the counters reach zero.

Decomposition:
- Shared package axi_isolate_pkg:
  - state enum isolate_state_e
  - AXI_RESP_DECERR = 2'b11
  - function cnt_width(max_outstanding)
- One sub-module axi_isolate_cnt:
  - parametrised up/down counter with inc, dec, at_max and is_zero outputs.
  - instantiated three times (wr, rd, w).

Test Plan:
- Idle port, isolate_i=1 at cycle 10 → isolated_o=1 at cycle 12; downstream aw_valid/ar_valid stay 0 while upstream valids are held high.
- Four AR (len=3) accepted, isolate_i raised, slave returns 16 beats → isolated_o stays 0 until the 4th r_last handshake, rises the next cycle; no AR issued after isolate.
- MAX_OUTSTANDING=2, three back-to-back AWs with B withheld → third aw_ready=0 until the first B handshake, then accepted.
- Downstream aw_ready=0 for 5 cycles while isolate_i rises mid-stall → aw_valid stays 1 until the handshake; wr_cnt=1; drain completes after the B.
- TERMINATE=1, isolated, AR id=0x2A len=2 → three R beats resp=2'b11 id=0x2A, r_last only on the 3rd; AW id=0x15 plus 1 W beat → one B resp=2'b11 id=0x15.
- rst_i asserted with wr_cnt=3 and state DRAIN → next cycle state NORMAL, busy_o=0, isolated_o=0.
